fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter MEM_SIZE, default 8: memory depth in words; SHALL be a power of 2.
REQ-002 Parameter PTR, default 3: pointer width; SHALL equal log2(MEM_SIZE).
REQ-003 Parameter AF_DEFAULT, default 6: almost-full threshold value after reset.
REQ-004 Parameter AE_DEFAULT, default 2: almost-empty threshold value after reset.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 init  input  1  flush and configure request.
REQ-008 thr_hi  input  PTR+1  almost-full threshold; sampled only in INIT.
REQ-009 thr_lo  input  PTR+1  almost-empty threshold; sampled only in INIT.
REQ-010 push_req  input  1  requester write request.
REQ-011 pop_req  input  1  requester read request.
REQ-012 push  output  1  qualified write enable to the memory.
REQ-013 pop  output  1  qualified read enable to the memory.
REQ-014 wr_ptr  output  PTR  memory write address.
REQ-015 rd_ptr  output  PTR  memory read address.
REQ-016 count  output  PTR+1  number of stored words.
REQ-017 full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-018 error  output  1  overflow/underflow indicator.
REQ-019 state  output  2  FSM state: INIT=0, IDLE=1, ACTIVE=2, ERROR=3.

Function
REQ-020 push and pop SHALL be combinational from the inputs and the registered state; all other outputs SHALL be registered or decoded from registers.
REQ-021 Overflow SHALL be detected when push_req=1, full=1 and pop_req=0.
REQ-022 Underflow SHALL be detected when pop_req=1 and empty=1, regardless of push_req.
REQ-023 push SHALL be high only when push_req=1, state is IDLE or ACTIVE, init=0, and no overflow or underflow is detected that cycle.
REQ-024 pop SHALL be high only when pop_req=1, state is IDLE or ACTIVE, init=0, and no overflow or underflow is detected that cycle.
REQ-025 When push=1 and full=1, pop SHALL also be 1; this pass-through leaves count unchanged.
REQ-026 push=1 SHALL advance wr_ptr by 1 modulo MEM_SIZE on the edge; pop=1 SHALL advance rd_ptr likewise; wrap is 7->0 at default sizing.
REQ-027 count SHALL increment on push-only, decrement on pop-only, and hold on both or neither.
REQ-028 count SHALL never exceed MEM_SIZE or go below 0.
REQ-029 Flags: full = (count==MEM_SIZE); empty = (count==0); almost_full = (count>=thr_hi_reg); almost_empty = (count<=thr_lo_reg).
REQ-030 INIT: pointers and count SHALL be held at 0 and error at 0; thr_hi/thr_lo SHALL be latched every cycle init=1; the FSM SHALL go to IDLE on the first edge with init=0.
REQ-031 IDLE (count==0): an edge with push=1 SHALL go to ACTIVE.
REQ-032 ACTIVE (count>0): an edge where count becomes 0 SHALL go to IDLE.
REQ-033 From IDLE or ACTIVE, an overflow or underflow SHALL go to ERROR on the next edge and set error=1.
REQ-034 In ERROR, push and pop SHALL be 0, and pointers and count SHALL hold.
REQ-035 ERROR SHALL be left only through init=1.
REQ-036 init=1 in any state SHALL go to INIT on the next edge and take priority over all other events.
REQ-037 Latency: a request accepted in cycle N SHALL be reflected in the pointers, count and flags after edge N.

Reset
REQ-038 reset=0 SHALL immediately force state=INIT, wr_ptr=0, rd_ptr=0, count=0, error=0, thr_hi_reg=AF_DEFAULT and thr_lo_reg=AE_DEFAULT; empty=1, full=0, almost_empty=1 and almost_full=0 follow from these values.
REQ-039 reset asserted mid-transfer SHALL discard all stored occupancy, with no partial pointer update.

Verification
REQ-040 Reset, then one cycle init=1 with thr_hi=6, thr_lo=2, then 8 consecutive push_req -> wr_ptr 0..7 then wraps to 0, count=8, full=1; almost_full=1 from count 6; state IDLE->ACTIVE.
REQ-041 From full, push_req=1 with pop_req=1 -> push=1, pop=1, count stays 8, both pointers advance by 1.
REQ-042 From full, push_req=1 alone -> push=0, state=ERROR and error=1 next cycle; count stays 8.
REQ-043 From empty IDLE, push_req=1 with pop_req=1 -> underflow: push=0, pop=0, state=ERROR.
REQ-044 Drain 3 of 3 words -> rd_ptr advances 3, count 3->0, empty=1, state ACTIVE->IDLE; almost_empty=1 once count<=2.
REQ-045 In ERROR, init=1 -> next state INIT with pointers=0 and error=0; reset=0 asserted mid-burst -> all outputs at REQ-038 values with no clock edge.

Source files
------------

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag controller for a single-clock FIFO.
// The memory is external. This block qualifies push/pop requests, tracks
// the read/write pointers and the word count, and reports overflow or
// underflow by moving to a sticky ERROR state.
//
// Request semantics: push_req/pop_req are requests, and push/pop are the
// grants. A grant is combinational in the same cycle, and the memory
// acts on it at the next rising edge.
module fifo_ctrl #(
  parameter int MEM_SIZE   = 8,
  parameter int PTR        = 3,
  parameter int AF_DEFAULT = 6,
  parameter int AE_DEFAULT = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           init,
  input  logic [PTR:0]   thr_hi,
  input  logic [PTR:0]   thr_lo,
  input  logic           push_req,
  input  logic           pop_req,
  output logic           push,
  output logic           pop,
  output logic [PTR-1:0] wr_ptr,
  output logic [PTR-1:0] rd_ptr,
  output logic [PTR:0]   count,
  output logic           full,
  output logic           empty,
  output logic           almost_full,
  output logic           almost_empty,
  output logic           error,
  output logic [1:0]     state
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  localparam logic [PTR:0] FULL_CNT = (PTR+1)'(MEM_SIZE);
  localparam logic [PTR:0] AF_RST   = (PTR+1)'(AF_DEFAULT);
  localparam logic [PTR:0] AE_RST   = (PTR+1)'(AE_DEFAULT);

  state_t         state_q, state_d;
  logic [PTR-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR:0]   count_q, count_d;
  logic [PTR:0]   thr_hi_q, thr_hi_d;
  logic [PTR:0]   thr_lo_q, thr_lo_d;
  logic           error_q, error_d;

  logic run;      // transfers may be granted this cycle
  logic ovf;      // overflow condition on current inputs
  logic udf;      // underflow condition on current inputs
  logic err_evt;  // an overflow/underflow that actually traps

  // Flags are decoded purely from registered state.
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= thr_hi_q);
  assign almost_empty = (count_q <= thr_lo_q);
  assign wr_ptr       = wr_ptr_q;
  assign rd_ptr       = rd_ptr_q;
  assign count        = count_q;
  assign error        = error_q;
  assign state        = state_q;

  // Request qualification: grants and error detection.
  // A push while full is legal only together with a pop (pass-through).
  always_comb begin
    ovf     = push_req & full & ~pop_req;
    udf     = pop_req & empty;
    run     = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) & ~init;
    err_evt = run & (ovf | udf);
    push    = run & push_req & ~ovf & ~udf;
    pop     = run & pop_req & ~ovf & ~udf;
  end

  // Datapath next-state: pointers, count, thresholds, sticky error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    thr_hi_d = thr_hi_q;
    thr_lo_d = thr_lo_q;
    error_d  = error_q;
    if (init || (state_q == ST_INIT)) begin
      // Flush: init wins over any request in flight this cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      error_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      if (err_evt) error_d = 1'b1;
    end
    if (init) begin
      thr_hi_d = thr_hi;
      thr_lo_d = thr_lo;
    end
  end

  // FSM next-state: init has priority; ERROR is left only through init.
  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT:   state_d = ST_IDLE;
        ST_IDLE: begin
          if (err_evt)   state_d = ST_ERROR;
          else if (push) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (err_evt)              state_d = ST_ERROR;
          else if (count_d == '0)   state_d = ST_IDLE;
        end
        ST_ERROR:  state_d = ST_ERROR;
        default:   state_d = ST_INIT;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      thr_hi_q <= AF_RST;
      thr_lo_q <= AE_RST;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      thr_hi_q <= thr_hi_d;
      thr_lo_q <= thr_lo_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl at default sizing (8 words, 3-bit pointers).
// Inputs change 1 ns after a rising edge; combinational grants are checked
// 1 ns later and registered outputs 1 ns after the following edge.
module tb_fifo_ctrl;

  logic       clk;
  logic       reset;
  logic       init;
  logic [3:0] thr_hi;
  logic [3:0] thr_lo;
  logic       push_req;
  logic       pop_req;
  logic       push;
  logic       pop;
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       error;
  logic [1:0] state;

  int tests;
  int fails;

  fifo_ctrl #(.MEM_SIZE(8), .PTR(3), .AF_DEFAULT(6), .AE_DEFAULT(2)) dut (
    .clk(clk), .reset(reset), .init(init), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .push_req(push_req), .pop_req(pop_req), .push(push), .pop(pop),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .count(count), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .error(error), .state(state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: one init pulse, then one cycle to reach IDLE.
  task automatic do_init(input logic [3:0] hi, input logic [3:0] lo);
    push_req = 1'b0;
    pop_req  = 1'b0;
    thr_hi   = hi;
    thr_lo   = lo;
    init     = 1'b1;
    step();
    tests++;
    if (state !== 2'd0 || count !== 4'd0 || wr_ptr !== 3'd0 || rd_ptr !== 3'd0 || error !== 1'b0) begin
      $display("FAIL init_flush: state=%0d count=%0d wr=%0d rd=%0d err=%0d, want 0 0 0 0 0",
               state, count, wr_ptr, rd_ptr, error);
      fails++;
    end
    init = 1'b0;
    step();
    tests++;
    if (state !== 2'd1) begin
      $display("FAIL init_to_idle: state=%0d want 1", state);
      fails++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; init = 1'b0; push_req = 1'b0; pop_req = 1'b0;
    thr_hi = 4'd0; thr_lo = 4'd0;
    #12;
    tests++;
    if ({state, wr_ptr, rd_ptr, count, error} !== {2'd0, 3'd0, 3'd0, 4'd0, 1'b0}) begin
      $display("FAIL reset_regs: state=%0d wr=%0d rd=%0d count=%0d err=%0d, want all 0",
               state, wr_ptr, rd_ptr, count, error);
      fails++;
    end
    tests++;
    if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
      $display("FAIL reset_flags: e/f/ae/af=%b want 1010", {empty, full, almost_empty, almost_full});
      fails++;
    end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  // Eight pushes from empty: pointer walk, count, almost_full from 6, full at 8.
  task automatic test_fill();
    do_init(4'd6, 4'd2);
    for (int i = 0; i < 8; i++) begin
      push_req = 1'b1;
      #1;
      tests++;
      if (push !== 1'b1 || pop !== 1'b0 || wr_ptr !== 3'(i)) begin
        $display("FAIL fill_grant[%0d]: push=%0d pop=%0d wr=%0d, want 1 0 %0d", i, push, pop, wr_ptr, i);
        fails++;
      end
      step();
      tests++;
      if (count !== 4'(i + 1) || state !== 2'd2 || almost_full !== (i + 1 >= 6) ||
          full !== (i == 7) || empty !== 1'b0) begin
        $display("FAIL fill_state[%0d]: count=%0d state=%0d af=%0d full=%0d empty=%0d, want %0d 2 %0d %0d 0",
                 i, count, state, almost_full, full, empty, i + 1, (i + 1 >= 6), (i == 7));
        fails++;
      end
    end
    push_req = 1'b0;
    tests++;
    if (wr_ptr !== 3'd0 || rd_ptr !== 3'd0) begin
      $display("FAIL fill_wrap: wr=%0d rd=%0d want 0 0", wr_ptr, rd_ptr);
      fails++;
    end
  endtask

  // Full with simultaneous push and pop: pass-through, count unchanged.
  task automatic test_passthrough();
    push_req = 1'b1; pop_req = 1'b1;
    #1;
    tests++;
    if (push !== 1'b1 || pop !== 1'b1) begin
      $display("FAIL pass_grant: push=%0d pop=%0d want 1 1", push, pop);
      fails++;
    end
    step();
    push_req = 1'b0; pop_req = 1'b0;
    tests++;
    if (count !== 4'd8 || wr_ptr !== 3'd1 || rd_ptr !== 3'd1 || full !== 1'b1 || state !== 2'd2) begin
      $display("FAIL pass_state: count=%0d wr=%0d rd=%0d full=%0d state=%0d, want 8 1 1 1 2",
               count, wr_ptr, rd_ptr, full, state);
      fails++;
    end
  endtask

  // Full with push alone: overflow traps; ERROR blocks everything; init recovers.
  task automatic test_overflow();
    push_req = 1'b1;
    #1;
    tests++;
    if (push !== 1'b0 || pop !== 1'b0) begin
      $display("FAIL ovf_grant: push=%0d pop=%0d want 0 0", push, pop);
      fails++;
    end
    step();
    tests++;
    if (state !== 2'd3 || error !== 1'b1 || count !== 4'd8) begin
      $display("FAIL ovf_state: state=%0d err=%0d count=%0d, want 3 1 8", state, error, count);
      fails++;
    end
    pop_req = 1'b1;
    #1;
    tests++;
    if (push !== 1'b0 || pop !== 1'b0) begin
      $display("FAIL err_block: push=%0d pop=%0d want 0 0", push, pop);
      fails++;
    end
    step();
    push_req = 1'b0; pop_req = 1'b0;
    tests++;
    if (state !== 2'd3 || wr_ptr !== 3'd1 || rd_ptr !== 3'd1 || count !== 4'd8 || error !== 1'b1) begin
      $display("FAIL err_hold: state=%0d wr=%0d rd=%0d count=%0d err=%0d, want 3 1 1 8 1",
               state, wr_ptr, rd_ptr, count, error);
      fails++;
    end
    do_init(4'd6, 4'd2);
  endtask

  // Empty IDLE with push and pop requested: underflow wins over the push.
  task automatic test_underflow();
    push_req = 1'b1; pop_req = 1'b1;
    #1;
    tests++;
    if (push !== 1'b0 || pop !== 1'b0) begin
      $display("FAIL udf_grant: push=%0d pop=%0d want 0 0", push, pop);
      fails++;
    end
    step();
    push_req = 1'b0; pop_req = 1'b0;
    tests++;
    if (state !== 2'd3 || error !== 1'b1 || count !== 4'd0 || wr_ptr !== 3'd0) begin
      $display("FAIL udf_state: state=%0d err=%0d count=%0d wr=%0d, want 3 1 0 0", state, error, count, wr_ptr);
      fails++;
    end
    do_init(4'd6, 4'd2);
  endtask

  // Write 3, drain 3: rd_ptr walk, almost_empty at <=2, ACTIVE->IDLE at 0.
  task automatic test_drain();
    push_req = 1'b1;
    repeat (3) step();
    push_req = 1'b0;
    tests++;
    if (count !== 4'd3 || almost_empty !== 1'b0 || wr_ptr !== 3'd3) begin
      $display("FAIL drain_pre: count=%0d ae=%0d wr=%0d, want 3 0 3", count, almost_empty, wr_ptr);
      fails++;
    end
    for (int i = 0; i < 3; i++) begin
      pop_req = 1'b1;
      step();
      tests++;
      if (count !== 4'(2 - i) || rd_ptr !== 3'(i + 1) || almost_empty !== 1'b1 ||
          empty !== (i == 2) || state !== ((i == 2) ? 2'd1 : 2'd2)) begin
        $display("FAIL drain[%0d]: count=%0d rd=%0d ae=%0d empty=%0d state=%0d, want %0d %0d 1 %0d %0d",
                 i, count, rd_ptr, almost_empty, empty, state, 2 - i, i + 1, (i == 2), (i == 2) ? 1 : 2);
        fails++;
      end
    end
    pop_req = 1'b0;
  endtask

  // Thresholds come from init, not from the live inputs.
  task automatic test_thresholds();
    do_init(4'd2, 4'd1);
    thr_hi = 4'd7; thr_lo = 4'd7;
    push_req = 1'b1;
    step();
    tests++;
    if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
      $display("FAIL thr_cnt1: af=%0d ae=%0d want 0 1", almost_full, almost_empty);
      fails++;
    end
    step();
    push_req = 1'b0;
    tests++;
    if (almost_full !== 1'b1 || almost_empty !== 1'b0 || count !== 4'd2) begin
      $display("FAIL thr_cnt2: af=%0d ae=%0d count=%0d want 1 0 2", almost_full, almost_empty, count);
      fails++;
    end
  endtask

  // Reset asserted between edges during a burst acts immediately.
  task automatic test_async_reset();
    do_init(4'd0, 4'd0);
    tests++;
    if (almost_full !== 1'b1) begin
      $display("FAIL thr_zero_af: af=%0d want 1", almost_full);
      fails++;
    end
    push_req = 1'b1;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if ({state, wr_ptr, rd_ptr, count, error, push} !== {2'd0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0}) begin
      $display("FAIL async_regs: state=%0d wr=%0d rd=%0d count=%0d err=%0d push=%0d, want all 0",
               state, wr_ptr, rd_ptr, count, error, push);
      fails++;
    end
    tests++;
    if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
      $display("FAIL async_flags: e/f/ae/af=%b want 1010", {empty, full, almost_empty, almost_full});
      fails++;
    end
    push_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fill();
    test_passthrough();
    test_overflow();
    test_underflow();
    test_drain();
    test_thresholds();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
